// File: rtl/bus_xfer_engine.sv
// bus_xfer_engine: single-bus register-transfer sequencer for the Mini SRC datapath.
// One command at a time; each T-state drives one source onto the bus and latches
// one destination. Optional HI/LO multiply support is built when HILO_MUL_EN is defined.
// Handshake: a command is taken on the clock edge where cmd_valid & cmd_ready are
// both high; cmd_ready is high only in IDLE (and never during reset). done pulses for
// one cycle when the command finishes, err pulses with it for an illegal opcode.
module bus_xfer_engine #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_ra,
    input  logic [REG_AW-1:0] cmd_rb,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] bus,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [2:0]        dbg_state
);

    localparam int NUM_GP = 2 ** REG_AW;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LDI  = 4'b0001;
    localparam logic [3:0] OP_MOV  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
`ifdef HILO_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_MFHI = 4'b1000;
    localparam logic [3:0] OP_MFLO = 4'b1001;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [REG_AW-1:0]   rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d, y_q, y_d, z_q, z_d, result_q, result_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   gp_q [NUM_GP];
    logic [DATA_W-1:0]   gp_d [NUM_GP];
    logic [DATA_W-1:0]   bus_w;
`ifdef HILO_MUL_EN
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*DATA_W-1:0] y_ext, b_ext, mul_full;
`endif

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_NOP, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: is_legal = 1'b1;
`ifdef HILO_MUL_EN
            OP_MUL, OP_MFHI, OP_MFLO: is_legal = 1'b1;
`endif
            default: is_legal = 1'b0;
        endcase
    endfunction

    // Ops that latch Y in T1 and continue to T2 (ALU ops and MUL).
    function automatic logic needs_y(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: needs_y = 1'b1;
`ifdef HILO_MUL_EN
            OP_MUL: needs_y = 1'b1;
`endif
            default: needs_y = 1'b0;
        endcase
    endfunction

    // Bus source select: pure decode of registered state and latched command.
    always_comb begin
        bus_w = '0;
        case (state_q)
            S_T1: begin
                case (op_q)
                    OP_LDI:  bus_w = mdr_q;
`ifdef HILO_MUL_EN
                    OP_MFHI: bus_w = hi_q;
                    OP_MFLO: bus_w = lo_q;
`endif
                    default: bus_w = gp_q[ra_q];
                endcase
            end
            S_T2:    bus_w = gp_q[rb_q];
            S_T3:    bus_w = z_q;
            default: bus_w = '0;
        endcase
    end

`ifdef HILO_MUL_EN
    // Sign-extend both operands so the low 2*DATA_W bits of the product are the signed result.
    assign y_ext    = {{DATA_W{y_q[DATA_W-1]}}, y_q};
    assign b_ext    = {{DATA_W{bus_w[DATA_W-1]}}, bus_w};
    assign mul_full = y_ext * b_ext;
`endif

    // Next-state and register-transfer logic for the T-state sequencer.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        mdr_d    = mdr_q;
        y_d      = y_q;
        z_d      = z_q;
        result_d = result_q;
        err_d    = err_q;
        gp_d     = gp_q;
`ifdef HILO_MUL_EN
        hi_d     = hi_q;
        lo_d     = lo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    rd_d = cmd_rd;
                    ra_d = cmd_ra;
                    rb_d = cmd_rb;
                    if (cmd_op == OP_LDI) mdr_d = cmd_data;
                    err_d = !is_legal(cmd_op);
                    if (cmd_op == OP_NOP || !is_legal(cmd_op)) state_d = S_DONE;
                    else                                        state_d = S_T1;
                end
            end
            S_T1: begin
                if (needs_y(op_q)) begin
                    y_d     = bus_w;
                    state_d = S_T2;
                end else begin
                    gp_d[rd_q] = bus_w;
                    result_d   = bus_w;
                    state_d    = S_DONE;
                end
            end
            S_T2: begin
`ifdef HILO_MUL_EN
                if (op_q == OP_MUL) begin
                    hi_d    = mul_full[2*DATA_W-1:DATA_W];
                    lo_d    = mul_full[DATA_W-1:0];
                    state_d = S_DONE;
                end else
`endif
                begin
                    case (op_q)
                        OP_ADD:  z_d = y_q + bus_w;
                        OP_SUB:  z_d = y_q - bus_w;
                        OP_AND:  z_d = y_q & bus_w;
                        default: z_d = y_q | bus_w;
                    endcase
                    state_d = S_T3;
                end
            end
            S_T3: begin
                gp_d[rd_q] = bus_w;
                result_d   = bus_w;
                state_d    = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; async clear drops any in-flight command.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            mdr_q    <= '0;
            y_q      <= '0;
            z_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
`ifdef HILO_MUL_EN
            hi_q     <= '0;
            lo_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            mdr_q    <= mdr_d;
            y_q      <= y_d;
            z_q      <= z_d;
            result_q <= result_d;
            err_q    <= err_d;
            gp_q     <= gp_d;
`ifdef HILO_MUL_EN
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`endif
        end
    end

    assign cmd_ready = (state_q == S_IDLE) && clear;
    assign done      = (state_q == S_DONE);
    assign err       = done && err_q;
    assign result    = result_q;
    assign bus       = bus_w;
    assign dbg_data  = gp_q[dbg_addr];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_xfer_engine.sv
// Directed testbench for bus_xfer_engine (DATA_W=32, REG_AW=4).
module tb_bus_xfer_engine;

    logic        clock, clear, cmd_valid, cmd_ready;
    logic [3:0]  cmd_op, cmd_rd, cmd_ra, cmd_rb, dbg_addr;
    logic [31:0] cmd_data, result, bus, dbg_data;
    logic        done, err;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    bus_xfer_engine #(.DATA_W(32), .REG_AW(4)) dut (
        .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_data(cmd_data), .done(done), .err(err), .result(result), .bus(bus),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present a command, wait for acceptance, return latency (edges from accept edge to done) and err.
    task automatic run_cmd(input logic [3:0] op, input int rd, input int ra, input int rb,
                           input logic [31:0] data, output int lat, output logic e);
        int guard;
        @(negedge clock);
        cmd_op = op; cmd_rd = rd[3:0]; cmd_ra = ra[3:0]; cmd_rb = rb[3:0]; cmd_data = data;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        e = err;
        if (!done) lat = -1;
    endtask

    task automatic rd_reg(input int a, output logic [31:0] v);
        dbg_addr = a[3:0];
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        int nz;
        clear = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
        cmd_data = '0; dbg_addr = '0;
        repeat (3) @(negedge clock);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
        checks++; if (bus !== 32'h0) begin errors++; $display("FAIL reset_bus got=%h exp=0", bus); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_done_err got=%b exp=00", {done, err}); end
        clear = 1'b1;
        @(negedge clock);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            rd_reg(i, v);
            if (v !== 32'h0) nz++;
        end
        checks++; if (nz !== 0) begin errors++; $display("FAIL reset_regs nonzero_count got=%0d exp=0", nz); end
    endtask

    task automatic test_ldi;
        int lat; logic e; logic [31:0] v;
        run_cmd(4'b0001, 0, 0, 0, 32'hAAAAAAAA, lat, e);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ldi_r0_latency got=%0d exp=2", lat); end
        run_cmd(4'b0001, 1, 0, 0, 32'h55555555, lat, e);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ldi_r1_latency got=%0d exp=2", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ldi_err got=%b exp=0", e); end
        rd_reg(0, v);
        checks++; if (v !== 32'hAAAAAAAA) begin errors++; $display("FAIL ldi_r0 got=%h exp=AAAAAAAA", v); end
        rd_reg(1, v);
        checks++; if (v !== 32'h55555555) begin errors++; $display("FAIL ldi_r1 got=%h exp=55555555", v); end
        checks++; if (result !== 32'h55555555) begin errors++; $display("FAIL ldi_result got=%h exp=55555555", result); end
    endtask

    task automatic test_alu;
        int lat; logic e; logic [31:0] v;
        run_cmd(4'b0011, 2, 0, 1, 32'h0, lat, e);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got=%0d exp=4", lat); end
        rd_reg(2, v);
        checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL add_r2 got=%h exp=FFFFFFFF", v); end
        checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL add_result got=%h exp=FFFFFFFF", result); end
        run_cmd(4'b0100, 3, 1, 0, 32'h0, lat, e);
        rd_reg(3, v);
        checks++; if (v !== 32'hAAAAAAAB) begin errors++; $display("FAIL sub_r3 got=%h exp=AAAAAAAB", v); end
        run_cmd(4'b0101, 4, 0, 1, 32'h0, lat, e);
        rd_reg(4, v);
        checks++; if (v !== 32'h00000000) begin errors++; $display("FAIL and_r4 got=%h exp=00000000", v); end
        run_cmd(4'b0110, 10, 0, 1, 32'h0, lat, e);
        rd_reg(10, v);
        checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL or_r10 got=%h exp=FFFFFFFF", v); end
        // destination equals both sources: R3 = R3 - R3
        run_cmd(4'b0100, 3, 3, 3, 32'h0, lat, e);
        rd_reg(3, v);
        checks++; if (v !== 32'h00000000) begin errors++; $display("FAIL sub_self_r3 got=%h exp=00000000", v); end
    endtask

    task automatic test_back_to_back;
        int k, done_at, ready_at, lat;
        logic [31:0] v;
        logic [31:0] bus_s [1:3];
        @(negedge clock);
        cmd_op = 4'b0011; cmd_rd = 4'd11; cmd_ra = 4'd0; cmd_rb = 4'd1; cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        // MOV R5=R2 held pending while the ADD runs
        cmd_op = 4'b0010; cmd_rd = 4'd5; cmd_ra = 4'd2; cmd_rb = 4'd0;
        k = 1; done_at = 0; ready_at = 0;
        while (ready_at == 0 && k < 20) begin
            if (k <= 3) bus_s[k] = bus;
            if (done && done_at == 0) done_at = k;
            if (cmd_ready) ready_at = k;
            else begin
                @(negedge clock);
                k++;
            end
        end
        checks++; if (bus_s[1] !== 32'hAAAAAAAA) begin errors++; $display("FAIL b2b_bus_t1 got=%h exp=AAAAAAAA", bus_s[1]); end
        checks++; if (bus_s[2] !== 32'h55555555) begin errors++; $display("FAIL b2b_bus_t2 got=%h exp=55555555", bus_s[2]); end
        checks++; if (bus_s[3] !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_bus_t3 got=%h exp=FFFFFFFF", bus_s[3]); end
        checks++; if (done_at !== 4) begin errors++; $display("FAIL b2b_add_done_at got=%0d exp=4", done_at); end
        checks++; if (ready_at !== 5) begin errors++; $display("FAIL b2b_first_ready_at got=%0d exp=5", ready_at); end
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_mov_latency got=%0d exp=2", lat); end
        rd_reg(5, v);
        checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_mov_r5 got=%h exp=FFFFFFFF", v); end
        rd_reg(11, v);
        checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_add_r11 got=%h exp=FFFFFFFF", v); end
    endtask

    task automatic test_mul;
        int lat; logic e; logic [31:0] v;
        logic [31:0] snap [16];
        int diff;
        run_cmd(4'b0001, 6, 0, 0, 32'hFFFFFFFE, lat, e);
        run_cmd(4'b0001, 7, 0, 0, 32'h00000003, lat, e);
        for (int i = 0; i < 16; i++) rd_reg(i, snap[i]);
`ifdef HILO_MUL_EN
        run_cmd(4'b0111, 0, 6, 7, 32'h0, lat, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mul_latency got=%0d exp=3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL mul_err got=%b exp=0", e); end
        checks++; if (result !== 32'h00000003) begin errors++; $display("FAIL mul_result_held got=%h exp=00000003", result); end
        diff = 0;
        for (int i = 0; i < 16; i++) begin rd_reg(i, v); if (v !== snap[i]) diff++; end
        checks++; if (diff !== 0) begin errors++; $display("FAIL mul_no_gp_write changed=%0d exp=0", diff); end
        run_cmd(4'b1000, 8, 0, 0, 32'h0, lat, e);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mfhi_latency got=%0d exp=2", lat); end
        rd_reg(8, v);
        checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL mfhi_r8 got=%h exp=FFFFFFFF", v); end
        run_cmd(4'b1001, 9, 0, 0, 32'h0, lat, e);
        rd_reg(9, v);
        checks++; if (v !== 32'hFFFFFFFA) begin errors++; $display("FAIL mflo_r9 got=%h exp=FFFFFFFA", v); end
        checks++; if (result !== 32'hFFFFFFFA) begin errors++; $display("FAIL mflo_result got=%h exp=FFFFFFFA", result); end
`else
        run_cmd(4'b0111, 0, 6, 7, 32'h0, lat, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL mul_off_latency got=%0d exp=1", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL mul_off_err got=%b exp=1", e); end
        run_cmd(4'b1000, 8, 0, 0, 32'h0, lat, e);
        checks++; if ({lat == 1, e} !== 2'b11) begin errors++; $display("FAIL mfhi_off lat=%0d err=%b exp lat=1 err=1", lat, e); end
        run_cmd(4'b1001, 9, 0, 0, 32'h0, lat, e);
        checks++; if ({lat == 1, e} !== 2'b11) begin errors++; $display("FAIL mflo_off lat=%0d err=%b exp lat=1 err=1", lat, e); end
        diff = 0;
        for (int i = 0; i < 16; i++) begin rd_reg(i, v); if (v !== snap[i]) diff++; end
        checks++; if (diff !== 0) begin errors++; $display("FAIL mul_off_regs changed=%0d exp=0", diff); end
        checks++; if (result !== 32'h00000003) begin errors++; $display("FAIL mul_off_result got=%h exp=00000003", result); end
`endif
    endtask

    task automatic test_illegal;
        int lat; logic e; logic [31:0] v;
        logic [31:0] snap [16];
        logic [31:0] res_snap;
        int diff;
        for (int i = 0; i < 16; i++) rd_reg(i, snap[i]);
        res_snap = result;
        run_cmd(4'b1111, 12, 0, 1, 32'h12345678, lat, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b exp=1", e); end
        run_cmd(4'b0000, 13, 0, 1, 32'h0, lat, e);
        checks++; if ({lat == 1, e} !== 2'b10) begin errors++; $display("FAIL nop lat=%0d err=%b exp lat=1 err=0", lat, e); end
        diff = 0;
        for (int i = 0; i < 16; i++) begin rd_reg(i, v); if (v !== snap[i]) diff++; end
        checks++; if (diff !== 0) begin errors++; $display("FAIL illegal_regs changed=%0d exp=0", diff); end
        checks++; if (result !== res_snap) begin errors++; $display("FAIL illegal_result got=%h exp=%h", result, res_snap); end
    endtask

    task automatic test_reset_midflight;
        int lat; logic e; logic [31:0] v;
        logic saw_done;
        @(negedge clock);
        cmd_op = 4'b0011; cmd_rd = 4'd2; cmd_ra = 4'd0; cmd_rb = 4'd1; cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        checks++; if (dbg_state !== 3'd2) begin errors++; $display("FAIL midrst_in_t2 got=%0d exp=2", dbg_state); end
        clear = 1'b0;
        #1;
        checks++; if (bus !== 32'h0) begin errors++; $display("FAIL midrst_bus got=%h exp=0", bus); end
        checks++; if ({cmd_ready, done, err} !== 3'b000) begin errors++; $display("FAIL midrst_ctrl got=%b exp=000", {cmd_ready, done, err}); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result got=%h exp=0", result); end
        rd_reg(0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL midrst_r0 got=%h exp=0", v); end
        rd_reg(2, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL midrst_r2 got=%h exp=0", v); end
        saw_done = 1'b0;
        repeat (3) begin @(negedge clock); if (done) saw_done = 1'b1; end
        clear = 1'b1;
        repeat (3) begin @(negedge clock); if (done) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got=%b exp=0", saw_done); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", cmd_ready); end
        run_cmd(4'b0001, 0, 0, 0, 32'hCAFEBABE, lat, e);
        checks++; if (lat !== 2) begin errors++; $display("FAIL midrst_ldi_latency got=%0d exp=2", lat); end
        rd_reg(0, v);
        checks++; if (v !== 32'hCAFEBABE) begin errors++; $display("FAIL midrst_ldi_r0 got=%h exp=CAFEBABE", v); end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu();
        test_back_to_back();
        test_mul();
        test_illegal();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
